// File: rtl/adder_pipe.sv
// Pipelined two's-complement add/sub: one CHUNK-bit slice resolves per stage,
// carry registered between stages, valid/ready handshake with full backpressure.

module adder_pipe_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L      = STAGES - 1;
  // B operand shrinks by CHUNK bits per level; all levels packed back to back.
  localparam int EB_W   = STAGES * WIDTH - CHUNK * STAGES * (STAGES - 1) / 2;

  logic [STAGES:0]                 vld_pipe;
  logic [STAGES-1:0][WIDTH-1:0]    w_q;
  logic [EB_W-1:0]                 eb_q;
  logic [STAGES-1:0]               c_q;
  logic [STAGES-1:0][CHUNK-1:0]    s_c;
  logic [STAGES-1:0]               co_c;
  logic                            adv;
  logic [WIDTH-1:0]                sum_d;

  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  // w holds unprocessed A slices at the bottom and finished result slices at
  // the top; each stage consumes the low slice and shifts its sum in from above.
  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int OFS = k * WIDTH - CHUNK * k * (k - 1) / 2;
    localparam int RW  = WIDTH - k * CHUNK;

    logic [WIDTH-1:0] w_r;
    logic [RW-1:0]    eb_r;
    logic             c_r;

    if (k == 0) begin : g_cap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_r  <= '0;
          eb_r <= '0;
          c_r  <= 1'b0;
        end else if (adv && in_valid) begin
          w_r  <= a;
          eb_r <= op[0] ? ~b : b;
          c_r  <= op[1] ? cin : op[0];
        end
      end
    end else begin : g_adv
      localparam int POFS = OFS - RW - CHUNK;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_r  <= '0;
          eb_r <= '0;
          c_r  <= 1'b0;
        end else if (adv && vld_pipe[k-1]) begin
          w_r  <= {s_c[k-1], w_q[k-1][WIDTH-1:CHUNK]};
          eb_r <= eb_q[POFS + CHUNK +: RW];
          c_r  <= co_c[k-1];
        end
      end
    end

    assign w_q[k]          = w_r;
    assign eb_q[OFS +: RW] = eb_r;
    assign c_q[k]          = c_r;

    adder_pipe_slice #(.CHUNK(CHUNK)) u_slice (
      .a  (w_q[k][CHUNK-1:0]),
      .b  (eb_q[OFS +: CHUNK]),
      .ci (c_q[k]),
      .s  (s_c[k]),
      .co (co_c[k])
    );
  end

  if (STAGES > 1) begin : g_sum_wide
    assign sum_d = {s_c[L], w_q[L][WIDTH-1:CHUNK]};
  end else begin : g_sum_one
    assign sum_d = s_c[L];
  end

  // Carry into the MSB is recovered as a^b^s of that bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (adv && vld_pipe[L]) begin
      sum  <= sum_d;
      cout <= co_c[L];
      ovf  <= co_c[L] ^ w_q[L][CHUNK-1] ^ eb_q[EB_W-1] ^ s_c[L][CHUNK-1];
      zero <= (sum_d == '0);
    end
  end
endmodule

// File: tb/tb_adder_pipe.sv
// Randomized bench for adder_pipe: scoreboard of arithmetic reference results,
// directed corner cases, stall/backpressure and mid-flight reset.

module tb_adder_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic [1:0]  op;
  logic        cin, cout, ovf, zero;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t exp_q[$];
  res_t h;
  bit   hold_chk;
  int   tests, fails, n_in, n_out;

  adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned sum for carry, signed range for overflow.
  function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [1:0] iop, input logic icin);
    res_t        r;
    logic [15:0] bb;
    int          ci, s;
    logic [31:0] u;
    bb = iop[0] ? ~ib : ib;
    ci = (iop == 2'd0) ? 0 : (iop == 2'd1) ? 1 : int'(icin);
    u  = 32'(ia) + 32'(bb) + 32'(ci);
    s  = int'($signed(ia)) + int'($signed(bb)) + ci;
    r.sum  = u[15:0];
    r.cout = u[16];
    r.ovf  = (s > 32767) || (s < -32768);
    r.zero = (u[15:0] == 16'h0);
    return r;
  endfunction

  task automatic step(input bit iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic [1:0] iop, input logic icin, input bit ordy);
    res_t e;
    in_valid = iv; a = ia; b = ib; op = iop; cin = icin; out_ready = ordy;
    #1;
    if (hold_chk) begin
      chk("hold_vld", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(h.sum));
      chk("hold_flags", {29'd0, cout, ovf, zero}, {29'd0, h.cout, h.ovf, h.zero});
    end
    hold_chk = out_valid && !out_ready;
    if (hold_chk) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      h = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.sum));
        chk("sb_flags", {29'd0, cout, ovf, zero}, {29'd0, e.cout, e.ovf, e.zero});
        n_out++;
      end
    end
    if (iv && in_ready) begin
      exp_q.push_back(model(ia, ib, iop, icin));
      n_in++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, ordy);
  endtask

  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] iop,
                         input logic icin, input logic [15:0] esum, input logic ec,
                         input logic eo, input logic ez);
    int cyc;
    step(1'b1, ia, ib, iop, icin, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      idle(1'b1);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
    chk("dir_sum", 32'(sum), 32'(esum));
    chk("dir_cout", 32'(cout), 32'(ec));
    chk("dir_ovf", 32'(ovf), 32'(eo));
    chk("dir_zero", 32'(zero), 32'(ez));
    idle(1'b1);
  endtask

  initial begin
    int cyc, in0, out0;
    tests = 0; fails = 0; n_in = 0; n_out = 0; hold_chk = 0;
    rst_n = 1'b0; in_valid = 0; a = '0; b = '0; op = '0; cin = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one(16'hFFFF, 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one(16'h7FFF, 16'h0001, 2'd0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_one(16'h0005, 16'h0007, 2'd1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_one(16'h8000, 16'h0001, 2'd1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_one(16'h00FF, 16'h0000, 2'd2, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_one(16'h0010, 16'h0001, 2'd3, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream with out_ready low 3 / high 2.
    in0 = n_in; out0 = n_out; cyc = 0;
    while (n_in - in0 < 20 && cyc < 300) begin
      step(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), (cyc % 5) >= 3);
      cyc++;
    end
    chk("stream_accepted", 32'(n_in - in0), 32'd20);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      idle((cyc % 5) >= 3);
      cyc++;
    end
    chk("stream_results", 32'(n_out - out0), 32'd20);
    chk("stream_q_empty", 32'(exp_q.size()), 32'd0);
    idle(1'b1);

    // Mid-flight reset with a result parked at the output.
    for (int i = 0; i < 3; i++)
      step(1'b1, 16'($urandom) | 16'h0101, 16'h1111, 2'd0, 1'b0, 1'b1);
    idle(1'b0);
    in_valid = 0; out_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_flags", {29'd0, cout, ovf, zero}, 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    hold_chk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("no_stale", 32'(out_valid), 32'd0);
      idle(1'b1);
    end
    run_one(16'h1234, 16'h1111, 2'd0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
